// File: rtl/shift_ctrl_pkg.sv
// Shared types and helpers for the shift_ctrl serial word exchanger.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Bit-counter width for a word of v bits; never less than one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/shift_ctrl_if.sv
// Word handshake and serial link bundle for shift_ctrl.
// parity_err exists only when SHIFT_CTRL_PARITY_EN is defined.
interface shift_ctrl_if #(
  parameter int unsigned n = 3
) ();

  logic         start_valid;
  logic         start_ready;
  logic [n-1:0] data_in;
  logic         shift_en;
  logic         sin;
  logic         ser_out;
  logic         busy;
  logic         done;
  logic [n-1:0] data_out;
`ifdef SHIFT_CTRL_PARITY_EN
  logic         parity_err;
`endif

  modport master (
    output start_valid, data_in, shift_en, sin,
    input  start_ready, ser_out, busy, done, data_out
`ifdef SHIFT_CTRL_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  start_valid, data_in, shift_en, sin,
    output start_ready, ser_out, busy, done, data_out
`ifdef SHIFT_CTRL_PARITY_EN
    , output parity_err
`endif
  );

endinterface

// File: rtl/shift_ctrl_reg.sv
// n-bit PIPO shift register: synchronous clear, parallel load, shift-in at LSB.
// Priority is clear, then load, then shift.
module shift_ctrl_reg #(
  parameter int unsigned n = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         shift,
  input  logic         sin,
  input  logic [n-1:0] d,
  output logic [n-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[n-2:0], sin};
    end
  end

endmodule

// File: rtl/shift_ctrl.sv
// Full-duplex serial word exchange controller: loads a word, shifts it out MSB-first
// while capturing sin, then pulses done with the received word. Parity stage: SHIFT_CTRL_PARITY_EN.
module shift_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned n = 3
) (
  input  logic      clk,
  input  logic      rst,
  shift_ctrl_if.slave bus
);

  localparam int unsigned cw = clog2(n);

  state_e        state_q, state_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic [n-1:0]  sr_q;
  logic [n-1:0]  dout_q, dout_d;
  logic          load_c, shift_c, last_c;
  logic          ready_q, busy_q, done_q;
`ifdef SHIFT_CTRL_PARITY_EN
  logic          ser_out_q, ser_out_d;
  logic          tx_par_q, tx_par_d;
  logic          perr_q, perr_d;
`endif

  shift_ctrl_reg #(.n(n)) u_reg (
    .clk   (clk),
    .clr   (rst),
    .load  (load_c),
    .shift (shift_c),
    .sin   (bus.sin),
    .d     (bus.data_in),
    .q     (sr_q)
  );

  assign last_c = (cnt_q == cw'(n - 1));

  // Next-state, register controls and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    load_c   = 1'b0;
    shift_c  = 1'b0;
`ifdef SHIFT_CTRL_PARITY_EN
    ser_out_d = ser_out_q;
    tx_par_d  = tx_par_q;
    perr_d    = perr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start_valid) begin
          state_d = ST_SHIFT;
          load_c  = 1'b1;
          cnt_d   = '0;
`ifdef SHIFT_CTRL_PARITY_EN
          ser_out_d = bus.data_in[n-1];
          tx_par_d  = ^bus.data_in;
`endif
        end
      end
      ST_SHIFT: begin
        if (bus.shift_en) begin
          shift_c = 1'b1;
`ifdef SHIFT_CTRL_PARITY_EN
          ser_out_d = sr_q[n-2];
`endif
          if (last_c) begin
            cnt_d = '0;
`ifdef SHIFT_CTRL_PARITY_EN
            state_d   = ST_PARITY;
            ser_out_d = tx_par_q;
`else
            state_d = ST_DONE;
            dout_d  = {sr_q[n-2:0], bus.sin};
`endif
          end else begin
            cnt_d = cnt_q + cw'(1);
          end
        end
      end
      ST_PARITY: begin
`ifdef SHIFT_CTRL_PARITY_EN
        // Register already holds the received word; only the parity bit is exchanged here.
        if (bus.shift_en) begin
          state_d   = ST_DONE;
          ser_out_d = sr_q[n-1];
          dout_d    = sr_q;
          perr_d    = bus.sin ^ (^sr_q);
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFT_CTRL_PARITY_EN
      ser_out_q <= 1'b0;
      tx_par_q  <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ready_q <= (state_d == ST_IDLE);
      busy_q  <= (state_d == ST_SHIFT) || (state_d == ST_PARITY);
      done_q  <= (state_d == ST_DONE);
`ifdef SHIFT_CTRL_PARITY_EN
      ser_out_q <= ser_out_d;
      tx_par_q  <= tx_par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign bus.start_ready = ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.data_out    = dout_q;
`ifdef SHIFT_CTRL_PARITY_EN
  assign bus.ser_out     = ser_out_q;
  assign bus.parity_err  = perr_q;
`else
  assign bus.ser_out     = sr_q[n-1];
`endif

endmodule
